if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline.
- Holds the PC, addresses instruction memory, and latches the fetched word plus PC+4 into IF/ID.
- Presents opcode/func to the main control decoder in ID.
- Handles stall, branch/jump redirect, and the STOP opcode (6'd63) halt-and-drain sequence.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- DRAIN_CYCLES, 4, non-stalled cycles after STOP enters IF/ID before halted asserts.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- stall  in  1  hazard unit: hold PC and IF/ID
- redirect_valid  in  1  taken branch/jump/jr from a later stage
- redirect_target  in  32  new byte PC; bits [1:0] ignored and forced to 0
- imem_addr  out  ADDR_W  word address = pc[ADDR_W+1:2], combinational from PC
- imem_rdata  in  32  instruction word, combinational read of imem_addr
- if_id_instr  out  32  latched instruction
- if_id_pc4  out  32  PC+4 of latched instruction
- if_id_valid  out  1  IF/ID holds a real instruction
- opcode_id  out  6  if_id_instr[31:26]
- func_id  out  6  if_id_instr[5:0]
- halted  out  1  fetch permanently stopped, pipeline drained
- fetch_count  out  32  accepted fetches, saturating

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC; if_id_instr=0; if_id_pc4=0; if_id_valid=0.
  - halted=0; fetch_count=0; state=RUN; drain counter=0.
  - Reset overrides all other inputs, in every state.
- States: RUN, DRAIN, HALTED. halted=1 exactly in HALTED, registered.
- Priority within a cycle: rst > redirect_valid > stall > normal.
- RUN, normal (no stall, no redirect):
  - if_id_instr<=imem_rdata; if_id_pc4<=pc+4; if_id_valid<=1; pc<=pc+4; fetch_count+=1.
  - One-cycle latency from PC to IF/ID.
- RUN, stall=1 and redirect_valid=0: pc, IF/ID, and fetch_count hold.
- Redirect (RUN or DRAIN, regardless of stall):
  - pc<={redirect_target[31:2],2'b00}; if_id_instr<=0 (NOP bubble); if_id_valid<=0; if_id_pc4<=0.
  - fetch_count unchanged.
  - In DRAIN, state<=RUN: cancels a wrong-path STOP.
- STOP detection: in RUN, on a normal cycle where imem_rdata[31:26]==6'd63:
  - STOP is latched into IF/ID (valid=1, counted) so the decoder sees it.
  - pc is held (not incremented).
  - state<=DRAIN; drain counter<=DRAIN_CYCLES.
- DRAIN:
  - pc frozen.
  - Each non-stalled, non-redirect cycle: IF/ID loads bubble (instr=0, valid=0) and the counter decrements.
  - When the counter is 1 and decrements, state<=HALTED.
  - stall holds both IF/ID and the counter.
  - Result: halted rises DRAIN_CYCLES non-stalled cycles after the STOP edge.
- HALTED:
  - pc, IF/ID (bubble), and fetch_count frozen.
  - redirect_valid and stall ignored; only rst exits.
- Arithmetic:
  - pc+4 is modulo 2^32; wrap from 32'hFFFF_FFFC goes to 0, no error.
  - imem_addr uses only pc[ADDR_W+1:2]; upper bits are silently aliased.
  - fetch_count saturates at 32'hFFFF_FFFF.
- DRAIN_CYCLES=0 is illegal; an elaboration-time check is required.

Test Plan:
- Reset, straight-line fetch: rst held 2 cycles, then imem returns 32'h2008_0005 at word 0 and 32'h0109_5020 at word 1.
  - Cycle 1: if_id_instr=32'h2008_0005, if_id_pc4=4, opcode_id=8.
  - Cycle 2: if_id_instr=32'h0109_5020, if_id_pc4=8, func_id=32, fetch_count=2.
- Stall: stall=1 for 3 cycles at pc=8 → pc, imem_addr=2, and IF/ID unchanged for 3 cycles; fetch resumes from word 2 after release.
- Redirect with stall: stall=1 and redirect_valid=1 with target 32'h0000_0043 in the same cycle.
  - Next cycle: pc=32'h40, imem_addr=16, if_id_valid=0, if_id_instr=0.
- STOP halt: word 3 = 32'hFC00_0000, DRAIN_CYCLES=4, no stalls.
  - Edge after fetch: opcode_id=63, if_id_valid=1.
  - Next 4 cycles: bubbles; halted=1 at the 4th, imem_addr stuck at 3.
  - Redirect thereafter is ignored.
- Redirect during DRAIN: redirect_valid=1 with target 32'h100 two cycles after STOP is latched.
  - halted never asserts; pc=32'h100; normal fetch resumes; state=RUN.
- Reset mid-halt: assert rst while halted=1 → next cycle halted=0, pc=RESET_PC, fetch_count=0; fetch restarts from word 0.

Source files
------------

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory port,
// and the IF/ID register view presented to decode.
interface if_stage_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              stall;
    logic              redirect_valid;
    logic [31:0]       redirect_target;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic [31:0]       if_id_instr;
    logic [31:0]       if_id_pc4;
    logic              if_id_valid;
    logic [5:0]        opcode_id;
    logic [5:0]        func_id;
    logic              halted;
    logic [31:0]       fetch_count;

    modport master (
        input  stall, redirect_valid, redirect_target, imem_rdata,
        output imem_addr, if_id_instr, if_id_pc4, if_id_valid,
               opcode_id, func_id, halted, fetch_count
    );

    modport slave (
        output stall, redirect_valid, redirect_target, imem_rdata,
        input  imem_addr, if_id_instr, if_id_pc4, if_id_valid,
               opcode_id, func_id, halted, fetch_count
    );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage with IF/ID register, stall/redirect handling
// and the STOP-opcode halt-and-drain sequence.
module if_stage #(
    parameter int unsigned ADDR_W       = 10,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.master  bus
);
    localparam int unsigned CNT_W   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [5:0]  OP_STOP = 6'd63;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    generate
        if (DRAIN_CYCLES == 0) begin : g_bad_drain
            $error("if_stage: DRAIN_CYCLES must be at least 1");
        end
    endgenerate

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_next4;
    logic [31:0] target;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
    logic [31:0] fetch_count;
    logic [CNT_W-1:0] drain_cnt;

    assign pc_next4 = 32'(pc + 32'd4);
    assign target   = bus.redirect_target & ~32'd3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            pc4         <= 32'd0;
            valid       <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= 32'd0;
            drain_cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.redirect_valid) begin
                        pc    <= target;
                        instr <= 32'd0;
                        pc4   <= 32'd0;
                        valid <= 1'b0;
                    end else if (!bus.stall) begin
                        instr <= bus.imem_rdata;
                        pc4   <= pc_next4;
                        valid <= 1'b1;
                        if (fetch_count != 32'hFFFF_FFFF) begin
                            fetch_count <= 32'(fetch_count + 32'd1);
                        end
                        // STOP is delivered to decode but the PC parks on it
                        if (bus.imem_rdata[31:26] == OP_STOP) begin
                            state     <= DRAIN;
                            drain_cnt <= CNT_W'(DRAIN_CYCLES);
                        end else begin
                            pc <= pc_next4;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.redirect_valid) begin
                        // A later-stage redirect means the STOP was on a wrong path
                        state     <= RUN;
                        drain_cnt <= '0;
                        pc        <= target;
                        instr     <= 32'd0;
                        pc4       <= 32'd0;
                        valid     <= 1'b0;
                    end else if (!bus.stall) begin
                        instr     <= 32'd0;
                        pc4       <= 32'd0;
                        valid     <= 1'b0;
                        drain_cnt <= CNT_W'(drain_cnt - CNT_W'(1));
                        if (drain_cnt == CNT_W'(1)) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign bus.imem_addr   = pc[ADDR_W+1:2];
    assign bus.if_id_instr = instr;
    assign bus.if_id_pc4   = pc4;
    assign bus.if_id_valid = valid;
    assign bus.opcode_id   = instr[31:26];
    assign bus.func_id     = instr[5:0];
    assign bus.halted      = halted;
    assign bus.fetch_count = fetch_count;
endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage: fetch, stall, redirect,
// STOP drain/halt, reset from halt, and PC wrap.
`timescale 1ns/1ps
module tb_if_stage;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] mem [0:1023];

    if_stage_if #(.ADDR_W(10)) bus ();

    if_stage #(
        .ADDR_W(10),
        .RESET_PC(32'h0000_0000),
        .DRAIN_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_rdata = mem[bus.imem_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'd0;
        for (int i = 0; i < cycles; i++) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.if_id_valid); end
        n_checks++; if (bus.if_id_instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr got %h want 0", bus.if_id_instr); end
        n_checks++; if (bus.if_id_pc4 !== 32'd0) begin n_fail++; $display("FAIL reset_pc4 got %h want 0", bus.if_id_pc4); end
        n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %0b want 0", bus.halted); end
        n_checks++; if (bus.fetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.fetch_count); end
        n_checks++; if (bus.imem_addr !== 10'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", bus.imem_addr); end
    endtask

    task automatic test_straight_fetch();
        step();
        n_checks++; if (bus.if_id_instr !== 32'h2008_0005) begin n_fail++; $display("FAIL fetch1_instr got %h want 20080005", bus.if_id_instr); end
        n_checks++; if (bus.if_id_pc4 !== 32'd4) begin n_fail++; $display("FAIL fetch1_pc4 got %h want 4", bus.if_id_pc4); end
        n_checks++; if (bus.opcode_id !== 6'd8) begin n_fail++; $display("FAIL fetch1_opcode got %0d want 8", bus.opcode_id); end
        n_checks++; if (bus.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL fetch1_valid got %0b want 1", bus.if_id_valid); end
        step();
        n_checks++; if (bus.if_id_instr !== 32'h0109_5020) begin n_fail++; $display("FAIL fetch2_instr got %h want 01095020", bus.if_id_instr); end
        n_checks++; if (bus.if_id_pc4 !== 32'd8) begin n_fail++; $display("FAIL fetch2_pc4 got %h want 8", bus.if_id_pc4); end
        n_checks++; if (bus.func_id !== 6'd32) begin n_fail++; $display("FAIL fetch2_func got %0d want 32", bus.func_id); end
        n_checks++; if (bus.fetch_count !== 32'd2) begin n_fail++; $display("FAIL fetch2_count got %0d want 2", bus.fetch_count); end
        n_checks++; if (bus.imem_addr !== 10'd2) begin n_fail++; $display("FAIL fetch2_addr got %0d want 2", bus.imem_addr); end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (bus.imem_addr !== 10'd2) begin n_fail++; $display("FAIL stall_addr[%0d] got %0d want 2", i, bus.imem_addr); end
            n_checks++; if (bus.if_id_instr !== 32'h0109_5020) begin n_fail++; $display("FAIL stall_instr[%0d] got %h want 01095020", i, bus.if_id_instr); end
            n_checks++; if (bus.if_id_pc4 !== 32'd8) begin n_fail++; $display("FAIL stall_pc4[%0d] got %h want 8", i, bus.if_id_pc4); end
            n_checks++; if (bus.fetch_count !== 32'd2) begin n_fail++; $display("FAIL stall_count[%0d] got %0d want 2", i, bus.fetch_count); end
        end
        bus.stall = 1'b0;
        step();
        n_checks++; if (bus.if_id_instr !== 32'h012A_4022) begin n_fail++; $display("FAIL resume_instr got %h want 012a4022", bus.if_id_instr); end
        n_checks++; if (bus.if_id_pc4 !== 32'd12) begin n_fail++; $display("FAIL resume_pc4 got %h want c", bus.if_id_pc4); end
        n_checks++; if (bus.fetch_count !== 32'd3) begin n_fail++; $display("FAIL resume_count got %0d want 3", bus.fetch_count); end
        n_checks++; if (bus.imem_addr !== 10'd3) begin n_fail++; $display("FAIL resume_addr got %0d want 3", bus.imem_addr); end
    endtask

    task automatic test_redirect_stall();
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0000_0043;
        step();
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        n_checks++; if (bus.imem_addr !== 10'd16) begin n_fail++; $display("FAIL redir_addr got %0d want 16", bus.imem_addr); end
        n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid got %0b want 0", bus.if_id_valid); end
        n_checks++; if (bus.if_id_instr !== 32'd0) begin n_fail++; $display("FAIL redir_instr got %h want 0", bus.if_id_instr); end
        n_checks++; if (bus.fetch_count !== 32'd3) begin n_fail++; $display("FAIL redir_count got %0d want 3", bus.fetch_count); end
        step();
        n_checks++; if (bus.if_id_instr !== 32'h2009_0007) begin n_fail++; $display("FAIL redir_fetch_instr got %h want 20090007", bus.if_id_instr); end
        n_checks++; if (bus.if_id_pc4 !== 32'h44) begin n_fail++; $display("FAIL redir_fetch_pc4 got %h want 44", bus.if_id_pc4); end
        n_checks++; if (bus.fetch_count !== 32'd4) begin n_fail++; $display("FAIL redir_fetch_count got %0d want 4", bus.fetch_count); end
    endtask

    // Reset, then run words 0..3 so STOP lands in IF/ID on the 4th edge.
    task automatic run_to_stop();
        do_reset(2);
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_stop_halt();
        run_to_stop();
        n_checks++; if (bus.opcode_id !== 6'd63) begin n_fail++; $display("FAIL stop_opcode got %0d want 63", bus.opcode_id); end
        n_checks++; if (bus.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL stop_valid got %0b want 1", bus.if_id_valid); end
        n_checks++; if (bus.if_id_pc4 !== 32'd16) begin n_fail++; $display("FAIL stop_pc4 got %h want 10", bus.if_id_pc4); end
        n_checks++; if (bus.fetch_count !== 32'd4) begin n_fail++; $display("FAIL stop_count got %0d want 4", bus.fetch_count); end
        n_checks++; if (bus.imem_addr !== 10'd3) begin n_fail++; $display("FAIL stop_addr got %0d want 3", bus.imem_addr); end
        for (int i = 1; i <= 4; i++) begin
            step();
            n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid[%0d] got %0b want 0", i, bus.if_id_valid); end
            n_checks++; if (bus.if_id_instr !== 32'd0) begin n_fail++; $display("FAIL drain_instr[%0d] got %h want 0", i, bus.if_id_instr); end
            n_checks++; if (bus.imem_addr !== 10'd3) begin n_fail++; $display("FAIL drain_addr[%0d] got %0d want 3", i, bus.imem_addr); end
            n_checks++; if (bus.halted !== (i == 4)) begin n_fail++; $display("FAIL drain_halted[%0d] got %0b want %0b", i, bus.halted, (i == 4)); end
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h100;
        bus.stall = 1'b1;
        step();
        step();
        bus.redirect_valid = 1'b0;
        bus.stall = 1'b0;
        n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold got %0b want 1", bus.halted); end
        n_checks++; if (bus.imem_addr !== 10'd3) begin n_fail++; $display("FAIL halt_addr got %0d want 3", bus.imem_addr); end
        n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid got %0b want 0", bus.if_id_valid); end
        n_checks++; if (bus.fetch_count !== 32'd4) begin n_fail++; $display("FAIL halt_count got %0d want 4", bus.fetch_count); end
    endtask

    task automatic test_reset_mid_halt();
        do_reset(1);
        n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL rsthalt_halted got %0b want 0", bus.halted); end
        n_checks++; if (bus.imem_addr !== 10'd0) begin n_fail++; $display("FAIL rsthalt_addr got %0d want 0", bus.imem_addr); end
        n_checks++; if (bus.fetch_count !== 32'd0) begin n_fail++; $display("FAIL rsthalt_count got %0d want 0", bus.fetch_count); end
        step();
        n_checks++; if (bus.if_id_instr !== 32'h2008_0005) begin n_fail++; $display("FAIL rsthalt_fetch got %h want 20080005", bus.if_id_instr); end
        n_checks++; if (bus.fetch_count !== 32'd1) begin n_fail++; $display("FAIL rsthalt_fcount got %0d want 1", bus.fetch_count); end
    endtask

    task automatic test_drain_redirect();
        run_to_stop();
        step();
        n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL dredir_bubble got %0b want 0", bus.if_id_valid); end
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        n_checks++; if (bus.imem_addr !== 10'h40) begin n_fail++; $display("FAIL dredir_addr got %0d want 64", bus.imem_addr); end
        n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL dredir_halted got %0b want 0", bus.halted); end
        n_checks++; if (bus.fetch_count !== 32'd4) begin n_fail++; $display("FAIL dredir_count got %0d want 4", bus.fetch_count); end
        step();
        n_checks++; if (bus.if_id_instr !== 32'h2010_0001) begin n_fail++; $display("FAIL dredir_fetch got %h want 20100001", bus.if_id_instr); end
        n_checks++; if (bus.if_id_pc4 !== 32'h104) begin n_fail++; $display("FAIL dredir_pc4 got %h want 104", bus.if_id_pc4); end
        n_checks++; if (bus.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL dredir_valid got %0b want 1", bus.if_id_valid); end
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL dredir_run_halted[%0d] got %0b want 0", i, bus.halted); end
        end
        n_checks++; if (bus.imem_addr !== 10'h47) begin n_fail++; $display("FAIL dredir_run_addr got %0d want 71", bus.imem_addr); end
        n_checks++; if (bus.fetch_count !== 32'd11) begin n_fail++; $display("FAIL dredir_run_count got %0d want 11", bus.fetch_count); end
    endtask

    task automatic test_pc_wrap();
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFE;
        step();
        bus.redirect_valid = 1'b0;
        n_checks++; if (bus.imem_addr !== 10'h3FF) begin n_fail++; $display("FAIL wrap_alias_addr got %0d want 1023", bus.imem_addr); end
        step();
        n_checks++; if (bus.if_id_instr !== 32'h2011_0002) begin n_fail++; $display("FAIL wrap_instr got %h want 20110002", bus.if_id_instr); end
        n_checks++; if (bus.if_id_pc4 !== 32'd0) begin n_fail++; $display("FAIL wrap_pc4 got %h want 0", bus.if_id_pc4); end
        n_checks++; if (bus.imem_addr !== 10'd0) begin n_fail++; $display("FAIL wrap_addr got %0d want 0", bus.imem_addr); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[0]    = 32'h2008_0005;
        mem[1]    = 32'h0109_5020;
        mem[2]    = 32'h012A_4022;
        mem[3]    = 32'hFC00_0000;
        mem[16]   = 32'h2009_0007;
        mem[64]   = 32'h2010_0001;
        mem[1023] = 32'h2011_0002;
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'd0;

        test_reset();
        test_straight_fetch();
        test_stall();
        test_redirect_stall();
        test_stop_halt();
        test_reset_mid_halt();
        test_drain_redirect();
        test_pc_wrap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
